// File: rtl/ex_operand_stage_pkg.sv
// Shared constants and types for the Cardinal ID/EX operand stage.
package ex_operand_stage_pkg;

  // Default hold length of a divide/modulo in EX.
  localparam int unsigned DefDivCycles = 4;

  // ALU opcodes.
  localparam logic [5:0] OpVand  = 6'd1;
  localparam logic [5:0] OpVor   = 6'd2;
  localparam logic [5:0] OpVxor  = 6'd3;
  localparam logic [5:0] OpVnot  = 6'd4;
  localparam logic [5:0] OpVmov  = 6'd5;
  localparam logic [5:0] OpVadd  = 6'd6;
  localparam logic [5:0] OpVsub  = 6'd7;
  localparam logic [5:0] OpVmule = 6'd8;
  localparam logic [5:0] OpVmulo = 6'd9;
  localparam logic [5:0] OpVsll  = 6'd10;
  localparam logic [5:0] OpVsrl  = 6'd11;
  localparam logic [5:0] OpVsra  = 6'd12;
  localparam logic [5:0] OpVrtth = 6'd13;
  localparam logic [5:0] OpVdivu = 6'd14;
  localparam logic [5:0] OpVmodu = 6'd15;

  // Element width encodings.
  localparam logic [1:0] WwByte   = 2'd0;
  localparam logic [1:0] WwHalf   = 2'd1;
  localparam logic [1:0] WwWord   = 2'd2;
  localparam logic [1:0] WwDouble = 2'd3;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StExec  = 2'd1,
    StMulti = 2'd2
  } ex_state_t;

  // Opcodes that occupy EX for more than one cycle.
  function automatic logic is_multi_op(input logic [5:0] op);
    return (op == OpVdivu) || (op == OpVmodu);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID/EX/WB signal bundle around the operand stage.
// master: the surrounding pipeline (ID, ALU, WB); slave: the operand stage.
interface ex_operand_stage_if #(
  parameter int unsigned RA_W = 5
) ();

  // From ID
  logic            id_valid;
  logic [5:0]      id_opcode;
  logic [1:0]      id_ww;
  logic [2:0]      id_ppp;
  logic [RA_W-1:0] id_ra;
  logic [RA_W-1:0] id_rb;
  logic [0:63]     id_ra_data;
  logic [0:63]     id_rb_data;
  logic [RA_W-1:0] id_rd;
  logic            id_we;
  logic            flush;
  // Feedback from ALU and WB
  logic [0:63]     alu_result;
  logic            wb_we;
  logic [RA_W-1:0] wb_rd;
  logic [0:63]     wb_data;
  // To ALU / EX-WB
  logic [0:63]     op1;
  logic [0:63]     op2;
  logic [5:0]      opcode;
  logic [1:0]      ww;
  logic [RA_W-1:0] ex_rd;
  logic            ex_we;
  logic [2:0]      ex_ppp;
  logic            ex_fire;
  logic            stall_id;

  modport master (
    output id_valid, id_opcode, id_ww, id_ppp, id_ra, id_rb, id_ra_data, id_rb_data,
    output id_rd, id_we, flush, alu_result, wb_we, wb_rd, wb_data,
    input  op1, op2, opcode, ww, ex_rd, ex_we, ex_ppp, ex_fire, stall_id
  );

  modport slave (
    input  id_valid, id_opcode, id_ww, id_ppp, id_ra, id_rb, id_ra_data, id_rb_data,
    input  id_rd, id_we, flush, alu_result, wb_we, wb_rd, wb_data,
    output op1, op2, opcode, ww, ex_rd, ex_we, ex_ppp, ex_fire, stall_id
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Three-way priority operand select: EX result, then WB data, then register file.
module ex_operand_stage_fwd_mux #(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] i_src,
  input  logic            i_ex_en,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic [0:63]     i_ex_data,
  input  logic            i_wb_we,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic [0:63]     i_wb_data,
  input  logic [0:63]     i_id_data,
  output logic [0:63]     o_data
);

  // Youngest producer wins; r0 is an ordinary register here.
  always_comb begin
    o_data = i_id_data;
    if (i_ex_en && (i_ex_rd == i_src)) begin
      o_data = i_ex_data;
    end else if (i_wb_we && (i_wb_rd == i_src)) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: captures decoded instructions, forwards operands and
// holds divide/modulo ops in EX for DIV_CYCLES cycles while stalling ID.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DefDivCycles,
  parameter int unsigned RA_W       = 5
) (
  input logic              clk,
  input logic              rst_n,
  ex_operand_stage_if.slave bus
);

  localparam int unsigned   CntW    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 1);
  localparam bit            MultiEn = (DIV_CYCLES > 1);

  ex_state_t       r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic            w_stall, w_fire, w_accept, w_start_multi, w_ex_fwd_en;
  logic [0:63]     w_op1_fwd, w_op2_fwd;

  logic [0:63]     r_op1, r_op2;
  logic [5:0]      r_opcode;
  logic [1:0]      r_ww;
  logic [RA_W-1:0] r_rd;
  logic            r_we;
  logic [2:0]      r_ppp;

  assign w_accept      = bus.id_valid && !w_stall && !bus.flush;
  assign w_start_multi = MultiEn && is_multi_op(bus.id_opcode);
  // A held divide exposes no partial result until its final cycle.
  assign w_ex_fwd_en   = w_fire && r_we;

  ex_operand_stage_fwd_mux #(
    .RA_W(RA_W)
  ) u_fwd_op1 (
    .i_src     (bus.id_ra),
    .i_ex_en   (w_ex_fwd_en),
    .i_ex_rd   (r_rd),
    .i_ex_data (bus.alu_result),
    .i_wb_we   (bus.wb_we),
    .i_wb_rd   (bus.wb_rd),
    .i_wb_data (bus.wb_data),
    .i_id_data (bus.id_ra_data),
    .o_data    (w_op1_fwd)
  );

  ex_operand_stage_fwd_mux #(
    .RA_W(RA_W)
  ) u_fwd_op2 (
    .i_src     (bus.id_rb),
    .i_ex_en   (w_ex_fwd_en),
    .i_ex_rd   (r_rd),
    .i_ex_data (bus.alu_result),
    .i_wb_we   (bus.wb_we),
    .i_wb_rd   (bus.wb_rd),
    .i_wb_data (bus.wb_data),
    .i_id_data (bus.id_rb_data),
    .o_data    (w_op2_fwd)
  );

  // State and hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next state: flush beats accept beats hold; otherwise fall to a bubble.
  always_comb begin
    w_state_d = StEmpty;
    w_cnt_d   = '0;
    if (bus.flush) begin
      w_state_d = StEmpty;
      w_cnt_d   = '0;
    end else if (w_accept) begin
      if (w_start_multi) begin
        w_state_d = StMulti;
        w_cnt_d   = CntLoad;
      end else begin
        w_state_d = StExec;
      end
    end else if (w_stall) begin
      w_state_d = StMulti;
      w_cnt_d   = r_cnt - CntW'(1);
    end
  end

  // Stall and fire decode from the current state only.
  always_comb begin
    w_stall = 1'b0;
    w_fire  = 1'b0;
    unique case (r_state)
      StEmpty: begin
        w_stall = 1'b0;
        w_fire  = 1'b0;
      end
      StExec: begin
        w_fire = 1'b1;
      end
      StMulti: begin
        w_stall = (r_cnt != '0);
        w_fire  = (r_cnt == '0);
      end
      default: begin
        w_stall = 1'b0;
        w_fire  = 1'b0;
      end
    endcase
  end

  // Pipeline registers: clear on bubble or flush, capture on accept, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_opcode <= '0;
      r_ww     <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_ppp    <= '0;
    end else if (bus.flush || (!w_accept && !w_stall)) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_opcode <= '0;
      r_ww     <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_ppp    <= '0;
    end else if (w_accept) begin
      r_op1    <= w_op1_fwd;
      r_op2    <= w_op2_fwd;
      r_opcode <= bus.id_opcode;
      r_ww     <= bus.id_ww;
      r_rd     <= bus.id_rd;
      r_we     <= bus.id_we;
      r_ppp    <= bus.id_ppp;
    end
  end

  assign bus.op1      = r_op1;
  assign bus.op2      = r_op2;
  assign bus.opcode   = r_opcode;
  assign bus.ww       = r_ww;
  assign bus.ex_rd    = r_rd;
  assign bus.ex_we    = r_we;
  assign bus.ex_ppp   = r_ppp;
  assign bus.ex_fire  = w_fire;
  assign bus.stall_id = w_stall;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage of the Cardinal processor, directly upstream of the combinational `alu`. Captures a decoded instruction from ID and resolves operand hazards by forwarding from the ALU result (EX) and the write-back port (WB). Drives registered `op1`/`op2`/`opcode`/`ww` into the ALU. Holds multi-cycle ops (`vdivu`, `vmodu`) in EX for a fixed number of cycles, stalling ID.

## Interface
Parameters:
- `DIV_CYCLES`, 4: cycles a `vdivu`/`vmodu` occupies EX. Must be ≥1; a value of 1 means single-cycle.
- `RA_W`, 5: register address width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID presents an instruction.
- `id_opcode` in 6: ALU opcode.
- `id_ww` in 2: element width.
- `id_ppp` in 3: participation field, passed through.
- `id_ra`, `id_rb` in RA_W: source register addresses.
- `id_ra_data`, `id_rb_data` in [0:63]: register file read data. Write-before-read.
- `id_rd` in RA_W: destination register.
- `id_we` in 1: instruction writes `id_rd`.
- `flush` in 1: squash the instruction in EX and drop ID's offer.
- `alu_result` in [0:63]: `alu_out` fed back.
- `wb_we` in 1: WB write strobe.
- `wb_rd` in RA_W: WB destination register.
- `wb_data` in [0:63]: WB data.
- `op1`, `op2` out [0:63]: ALU operands, registered.
- `opcode` out 6: to ALU, registered.
- `ww` out 2: to ALU, registered.
- `ex_rd` out RA_W: destination register of the EX instruction.
- `ex_we` out 1: EX instruction writes a register. Zero for a bubble.
- `ex_ppp` out 3: participation field of the EX instruction.
- `ex_fire` out 1: `alu_out` is final this cycle. EX/WB samples it.
- `stall_id` out 1: ID must hold its instruction and re-read the register file.

## Operation
- States: `EMPTY` (bubble), `EXEC` (single-cycle op), `MULTI` (div/mod hold). Down-counter `cnt` of width clog2(DIV_CYCLES).
- `stall_id = (state==MULTI) && (cnt != 0)`. Purely combinational from state.
- Accept:
  - `accept = id_valid && !stall_id && !flush`.
  - On accept, capture all fields.
  - Next state is `MULTI` with `cnt = DIV_CYCLES-1` if the opcode is 14 or 15 and `DIV_CYCLES > 1`. Otherwise next state is `EXEC`.
- No accept and no stall:
  - State goes to `EMPTY`.
  - `opcode`, `ex_we`, `op1`, `op2` all become 0, so the ALU outputs 0.
- `MULTI` with `cnt != 0`: `cnt` decrements and all outputs hold.
- `MULTI` with `cnt == 0`: acts like `EXEC`, so the next instruction may be accepted.
- `ex_fire = (state==EXEC) || (state==MULTI && cnt==0)`. Never high in `EMPTY`.
- Forwarding at capture, per source; `op1` uses `id_ra`, `op2` uses `id_rb`. Priority:
  1. If `ex_fire && ex_we && ex_rd == src`, use `alu_result`.
  2. Else if `wb_we && wb_rd == src`, use `wb_data`.
  3. Else use the ID data.
- No special zero register; r0 forwards like any other register.
- `flush`:
  - Takes priority over everything.
  - Next state is `EMPTY` and `cnt` clears, so a div hold in progress is aborted.
  - ID's offer that cycle is not accepted.
  - `stall_id` that cycle still follows the current state.
- Reset mid-operation aborts any hold immediately. No partial result is ever signalled.

## Timing
- Reset values: every output 0 and state `EMPTY`. In particular `stall_id` = 0 and `ex_fire` = 0.
- Capture-to-ALU latency is 1 cycle. Outputs change only on the `clk` edge or on `rst_n` assertion.
- Single-cycle op: `ex_fire` is high the cycle after accept. Back-to-back accepts sustain 1 instruction per cycle.
- Div/mod with `DIV_CYCLES = N`: occupies EX for N cycles.
  - `stall_id` is high for the first N-1 of them.
  - `ex_fire` is high only on the Nth.
  - The next instruction is accepted on the Nth cycle edge.
- `alu_result` is forwarded only when `ex_fire` is high. A held div never forwards partial values.

## Structure
- `cardinal_pkg` holds:
  - Opcode constants (`OP_VDIVU` = 14, `OP_VMODU` = 15, etc.).
  - `ww` encodings.
  - State enum `ex_state_t` {EMPTY, EXEC, MULTI}.
  - Default `DIV_CYCLES`.
- Sub-module `fwd_mux`: the 3-way priority operand mux, instantiated twice. It is purely combinational. The top level contains the FSM, counter and registers.

## Test plan
- Reset: assert `rst_n` low during a `vdivu` hold with `cnt` = 2 → all outputs 0 immediately. After release, state is `EMPTY` and `stall_id` is 0.
- EX forward: `vadd r3` then `vand r4, r3, r5` on consecutive cycles, with `alu_result` = 0x0000_0000_0000_0011 and stale `id_ra_data` = 0 → `op1` = 0x11.
- Priority: EX and WB both target r7 (`alu_result` = 0xAA.., `wb_data` = 0x55..) → `op1` = 0xAA...
- Multicycle: `vdivu` with DIV_CYCLES = 4 → `stall_id` is 1,1,1,0, `ex_fire` is 0,0,0,1, and the following `vor` is accepted on the 4th edge.
- Flush: `flush` on the 2nd hold cycle of a `vmodu` → next cycle state is `EMPTY`, `opcode` = 0, `stall_id` = 0, `ex_fire` = 0.
- Bubble: `id_valid` = 0 for 2 cycles after a `vxor` → `ex_fire` is 1 then 0, and `ex_we` and `opcode` are 0 during the bubble.
